// File: rtl/gpu_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_cmd_pkg
// Purpose  : Shared opcode constants, payload-length helper and fetch FSM
//            state encoding for the geometry command-stream front end.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_cmd_pkg;

  localparam logic [7:0] OP_END         = 8'h00;
  localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
  localparam logic [7:0] OP_VERTEX      = 8'h11;
  localparam logic [7:0] OP_LOAD_MATRIX = 8'h13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_EMIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // Payload length in 32-bit words that follows a header of the given opcode.
  function automatic logic [4:0] payload_len(input logic [7:0] op);
    logic [4:0] len;
    case (op)
      OP_VERTEX:      len = 5'd4;
      OP_LOAD_MATRIX: len = 5'd16;
      default:        len = 5'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_hdr_decode.sv
`default_nettype none
// ============================================================================
// Module   : cmd_hdr_decode
// Purpose  : Combinational command-header decoder: legality, END detection,
//            payload length, beat count, argument byte and column-major flag.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_hdr_decode
  import gpu_cmd_pkg::*;
(
  input  logic [31:0] hdr_i,
  output logic        legal_o,
  output logic        is_end_o,
  output logic [4:0]  len_o,
  output logic [2:0]  beats_o,
  output logic [7:0]  arg_o,
  output logic        flag_o
);

  logic [7:0] w_op;
  logic [4:0] w_len;
  logic       w_unused_hdr;

  assign w_op  = hdr_i[7:0];
  assign w_len = payload_len(w_op);

  // Header bits 30:16 carry no meaning for the current opcode set.
  assign w_unused_hdr = ^hdr_i[30:16];

  // Classify the opcode and derive the number of quad beats (at least one).
  always_comb begin
    legal_o  = 1'b0;
    is_end_o = 1'b0;
    case (w_op)
      OP_END:         is_end_o = 1'b1;
      OP_MATRIX_MODE,
      OP_VERTEX,
      OP_LOAD_MATRIX: legal_o  = 1'b1;
      default:        legal_o  = 1'b0;
    endcase
    len_o   = w_len;
    beats_o = (w_len[4:2] == 3'd0) ? 3'd1 : w_len[4:2];
    arg_o   = hdr_i[15:8];
    flag_o  = hdr_i[31];
  end

endmodule
`default_nettype wire

// File: rtl/cmd_stream_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cmd_stream_fetch
// Purpose  : Walks the command stream in BRAM, decodes headers, fetches
//            payload as 4-word quads and presents each command as a series
//            of valid/ready beats to the matrix/vertex unit.
// Options  : CMD_STREAM_FETCH_PERF_EN adds perf_cmds / perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_stream_fetch
  import gpu_cmd_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LIMIT_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       cmd_word,
  input  logic [31:0]       data0,
  input  logic [31:0]       data1,
  input  logic [31:0]       data2,
  input  logic [31:0]       data3,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [7:0]        op_code,
  output logic [7:0]        op_arg,
  output logic              op_flag,
  output logic [127:0]      op_data,
  output logic              op_first,
  output logic              op_last,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef CMD_STREAM_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_cmds,
  output logic [15:0]       perf_stall
`endif
);

  localparam logic [ADDR_W-3:0] LIMIT_IDX = (ADDR_W-2)'(LIMIT_WORDS);
  localparam logic [ADDR_W-1:0] WORD_B    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] QUAD_B    = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] ALIGN_M   = ~ADDR_W'(3);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [2:0]        beat_q;
  logic [2:0]        nbeats_q;
  logic [4:0]        len_q;
  logic [7:0]        code_q;
  logic [7:0]        arg_q;
  logic              flag_q;
  logic              done_q;
  logic              error_q;

  logic              dec_legal;
  logic              dec_is_end;
  logic [4:0]        dec_len;
  logic [2:0]        dec_beats;
  logic [7:0]        dec_arg;
  logic              dec_flag;

  logic [ADDR_W:0]   w_end_d;
  logic [ADDR_W-1:0] w_ptr_d;
  logic              w_hdr_over;
  logic              w_pay_over;
  logic              w_start_ok;
  logic              w_emit;
  logic              w_fire;
  logic              w_last;

  cmd_hdr_decode u_dec (
    .hdr_i    (cmd_word),
    .legal_o  (dec_legal),
    .is_end_o (dec_is_end),
    .len_o    (dec_len),
    .beats_o  (dec_beats),
    .arg_o    (dec_arg),
    .flag_o   (dec_flag)
  );

  // Bounds checks on the header and on the last payload word, with the
  // carry bit kept so that address wrap-around counts as an overrun.
  assign w_end_d    = {1'b0, ptr_q} + {{(ADDR_W-6){1'b0}}, dec_len, 2'b00};
  assign w_hdr_over = (ptr_q[ADDR_W-1:2] >= LIMIT_IDX);
  assign w_pay_over = w_end_d[ADDR_W] || (w_end_d[ADDR_W-1:2] >= LIMIT_IDX);
  assign w_ptr_d    = ptr_q + WORD_B + {{(ADDR_W-7){1'b0}}, len_q, 2'b00};

  assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERROR));
  assign w_emit     = (state_q == ST_EMIT);
  assign w_fire     = w_emit && op_ready;
  assign w_last     = (beat_q == (nbeats_q - 3'd1));

  assign cmd_addr  = ptr_q;
  assign data_addr = daddr_q;
  assign op_valid  = w_emit;
  assign op_code   = w_emit ? code_q : 8'h00;
  assign op_arg    = w_emit ? arg_q  : 8'h00;
  assign op_flag   = w_emit && flag_q;
  assign op_first  = w_emit && (beat_q == 3'd0);
  assign op_last   = w_emit && w_last;
  assign op_data   = (w_emit && (code_q != OP_MATRIX_MODE)) ?
                     {data3, data2, data1, data0} : 128'd0;
  assign busy      = (state_q == ST_HDR) || w_emit;
  assign done      = done_q;
  assign error     = error_q;

  // Fetch FSM: header decode, bounds check, beat sequencing and pointer walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      daddr_q  <= '0;
      beat_q   <= 3'd0;
      nbeats_q <= 3'd0;
      len_q    <= 5'd0;
      code_q   <= 8'h00;
      arg_q    <= 8'h00;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_start_ok) begin
            ptr_q   <= base_addr & ALIGN_M;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_hdr_over) begin
            error_q <= 1'b1;
            state_q <= ST_ERROR;
          end else if (dec_is_end) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (!dec_legal || w_pay_over) begin
            error_q <= 1'b1;
            state_q <= ST_ERROR;
          end else begin
            code_q   <= cmd_word[7:0];
            arg_q    <= dec_arg;
            flag_q   <= dec_flag;
            len_q    <= dec_len;
            nbeats_q <= dec_beats;
            beat_q   <= 3'd0;
            daddr_q  <= ptr_q + WORD_B;
            state_q  <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_fire) begin
            daddr_q <= daddr_q + QUAD_B;
            beat_q  <= beat_q + 3'd1;
            if (w_last) begin
              ptr_q   <= w_ptr_d;
              state_q <= ST_HDR;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CMD_STREAM_FETCH_PERF_EN
  logic [15:0] perf_cmds_q;
  logic [15:0] perf_stall_q;

  assign perf_cmds  = perf_cmds_q;
  assign perf_stall = perf_stall_q;

  // Saturating counters of completed commands and back-pressured beat cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmds_q  <= 16'd0;
      perf_stall_q <= 16'd0;
    end else if (w_start_ok) begin
      perf_cmds_q  <= 16'd0;
      perf_stall_q <= 16'd0;
    end else begin
      if (w_fire && w_last && (perf_cmds_q != 16'hFFFF)) begin
        perf_cmds_q <= perf_cmds_q + 16'd1;
      end
      if (w_emit && !op_ready && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/cmd_stream_fetch.md
Name: cmd_stream_fetch

Overview:
- Command-stream front end of the geometry pipeline. Sits directly in front of the command BRAM and drives its two byte-address read ports.
- Walks the command stream word by word and decodes each command header. Fetches payload words as 4-word quads through the second read port.
- Presents each command to the downstream matrix/vertex unit as a sequence of beats on a valid/ready handshake.

Parameters:
- ADDR_W, 32, byte-address width of the BRAM ports.
- LIMIT_WORDS, 64, maximum stream length in words; the fetch pointer must stay below this.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins fetch at base_addr; ignored unless in IDLE, DONE or ERROR.
- base_addr  in  ADDR_W  byte address of the first header; bits[1:0] ignored.
- cmd_addr  out  ADDR_W  header read address, feeds BRAM port 1.
- data_addr  out  ADDR_W  payload quad read address, feeds BRAM port 2.
- cmd_word  in  32  header word at cmd_addr; combinational, zero latency.
- data0..data3  in  32 each  words at data_addr, +4, +8, +12; combinational.
- op_valid  out  1  beat valid.
- op_ready  in  1  downstream accepts the beat.
- op_code  out  8  header bits[7:0].
- op_arg  out  8  header bits[15:8]; carries the mode index for MATRIX_MODE.
- op_flag  out  1  header bit31; column-major flag for LOAD_MATRIX.
- op_data  out  128  payload quad, {data3,data2,data1,data0}.
- op_first  out  1  first beat of a command.
- op_last  out  1  last beat of a command.
- busy  out  1  high in any state other than IDLE, DONE or ERROR.
- done  out  1  END header reached.
- error  out  1  unknown opcode or pointer overrun.

Behaviour:
- Opcodes (header[7:0]) and payload length:
  - 0x00 END: no payload.
  - 0x10 MATRIX_MODE: 0 payload words.
  - 0x11 VERTEX: 4 payload words.
  - 0x13 LOAD_MATRIX: 16 payload words.
  - Any other value is illegal.
- Reset: state IDLE, ptr=0, beat counter=0, all outputs 0.
- States:
  - IDLE / DONE / ERROR: start loads ptr=base_addr & ~3, clears done and error, goes to HDR.
  - HDR: cmd_addr=ptr. Decode cmd_word combinationally.
    - END: done=1, go to DONE. No beat is emitted.
    - Illegal opcode: error=1, go to ERROR.
    - Legal opcode: latch header; data_addr=ptr+4; beats=max(1, len/4); go to EMIT.
  - EMIT: op_valid=1.
    - op_data is the current quad; it is 0 for MATRIX_MODE.
    - op_first=1 on beat 0; op_last=1 on the final beat.
    - A beat completes when op_valid && op_ready. On completion data_addr advances by 16.
    - After the last beat: ptr += 4 + 4*len, go to HDR.
- Handshake:
  - op_* must be held stable while op_valid && !op_ready.
  - op_valid never drops without a handshake.
- Latency: header in HDR on cycle N, first beat valid on N+1. With op_ready held high:
  - LOAD_MATRIX takes 5 cycles total.
  - VERTEX takes 2 cycles.
  - MATRIX_MODE takes 2 cycles.
- Overrun: if the header or any payload word index (ptr>>2) is >= LIMIT_WORDS, set error=1 and go to ERROR. This check happens before any beat of that command is emitted.
- ptr arithmetic is ADDR_W bits. Wrap-around is treated as overrun.
- start while busy is ignored.
- Reset asserted mid-command aborts immediately. No partial beat remains visible after rst.

Optional Feature:
- Macro: CMD_STREAM_FETCH_PERF_EN.
- Defined: adds output perf_cmds (16 bits), counting completed commands excluding END. Adds output perf_stall (16 bits), counting cycles with op_valid && !op_ready. Both counters saturate at the maximum value, clear on start, and reset to 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package gpu_cmd_pkg holds:
  - opcode constants OP_END, OP_MATRIX_MODE, OP_VERTEX, OP_LOAD_MATRIX;
  - a payload-length function;
  - the state enum.
- One natural sub-module, cmd_hdr_decode (combinational): takes the header and returns legal, len, beats, arg and flag.

Test Plan:
- MATRIX_MODE header 0x00000110 at 0, then END at 4, op_ready=1 → one beat with op_code=0x10, op_arg=0x01, op_first=op_last=1, op_data=0; done=1 two cycles later.
- LOAD_MATRIX 0x80001013 at 0 with 16 payload words, then END at 68 → 4 beats with data_addr 4, 20, 36, 52; op_flag=1; op_last on beat 3; ptr reaches 68.
- VERTEX 0x00000011 with op_ready held low for 3 cycles → op_valid and op_data are stable for 3 cycles; perf_stall=3 when the macro is defined.
- Header 0x00000042 → error=1, no beat emitted, busy=0. A subsequent start succeeds.
- LOAD_MATRIX placed at word LIMIT_WORDS-4 → error=1 before any beat.
- rst asserted mid-LOAD_MATRIX on beat 2 → all outputs 0 immediately, state IDLE.
